operand_fetch_stage: RTL and testbench

- Sits directly downstream of file_register: drives its read0_addr/read1_addr and consumes read0_data/read1_data.
- Resolves forwarding from the EX and WB stages and detects load-use hazards, inserting a one-cycle bubble when needed.
- Registers operands, destination and valid into the ID/EX pipeline register that feeds the ALU.
- The file register writes on the clock edge, so a same-cycle WB write is not visible on its read ports; forwarding covers this.

---
 rtl/operand_fetch_stage_pkg.sv | 7 +
 rtl/operand_fetch_stage_forward_mux.sv | 21 ++
 rtl/operand_fetch_stage.sv | 92 +++++++++
 tb/tb_operand_fetch_stage.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/operand_fetch_stage_pkg.sv
// operand_fetch_stage_pkg: shared widths, zero-register index and FSM encoding for the operand fetch stage.
package operand_fetch_stage_pkg;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam logic [ADDR_W-1:0] ZERO_REG = 5'd31;
    typedef enum logic {RUN = 1'b0, BUBBLE = 1'b1} state_t;
endpackage

// File: rtl/operand_fetch_stage_forward_mux.sv
// forward_mux_32bit: picks one source operand from zero, EX result, WB data or the register read port.
module forward_mux_32bit
    import operand_fetch_stage_pkg::*;
(
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] reg_data,
    input  logic              ex_we,
    input  logic              ex_is_load,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic [DATA_W-1:0] ex_data,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] operand
);
    // A load in EX has no data yet; the hazard logic bubbles instead of forwarding it.
    always_comb
        operand = (addr == ZERO_REG)                         ? '0      :
                  (ex_we && !ex_is_load && ex_addr == addr) ? ex_data :
                  (wb_we && wb_addr == addr)                ? wb_data : reg_data;
endmodule

// File: rtl/operand_fetch_stage.sv
// operand_fetch_stage: reads/forwards operands, inserts a load-use bubble and registers the ID/EX stage.
module operand_fetch_stage
    import operand_fetch_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst_all,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] src0_addr,
    input  logic [ADDR_W-1:0] src1_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic              dst_we,
    input  logic              is_load,
    output logic [ADDR_W-1:0] read0_addr,
    output logic [ADDR_W-1:0] read1_addr,
    input  logic [DATA_W-1:0] read0_data,
    input  logic [DATA_W-1:0] read1_data,
    input  logic              ex_we,
    input  logic              ex_is_load,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic [DATA_W-1:0] ex_data,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              out_stall,
    input  logic              flush,
    output logic [DATA_W-1:0] op0,
    output logic [DATA_W-1:0] op1,
    output logic [ADDR_W-1:0] out_dst_addr,
    output logic              out_dst_we,
    output logic              out_is_load,
    output logic              out_valid
);
    state_t state, state_nxt;
    logic hazard, capture;
    logic [DATA_W-1:0] sel0, sel1;

    assign read0_addr = src0_addr;
    assign read1_addr = src1_addr;
    assign hazard = in_valid && ex_we && ex_is_load && ex_addr != ZERO_REG &&
                    (ex_addr == src0_addr || ex_addr == src1_addr);

    forward_mux_32bit u_fwd0 (
        .addr(src0_addr), .reg_data(read0_data),
        .ex_we(ex_we), .ex_is_load(ex_is_load), .ex_addr(ex_addr), .ex_data(ex_data),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .operand(sel0)
    );

    forward_mux_32bit u_fwd1 (
        .addr(src1_addr), .reg_data(read1_data),
        .ex_we(ex_we), .ex_is_load(ex_is_load), .ex_addr(ex_addr), .ex_data(ex_data),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .operand(sel1)
    );

    always_ff @(posedge clk or posedge rst_all)
        if (rst_all) state <= RUN;
        else         state <= state_nxt;

    always_comb begin
        state_nxt = state;
        in_ready  = !out_stall && state == RUN && !hazard;
        capture   = in_valid && in_ready;
        if (flush)
            state_nxt = RUN;
        else if (!out_stall)
            state_nxt = (state == RUN && hazard) ? BUBBLE : RUN;
    end

    // Any non-capturing, non-stalled edge (bubble, idle or flush) leaves an empty slot.
    always_ff @(posedge clk or posedge rst_all) begin
        if (rst_all) begin
            op0          <= '0;
            op1          <= '0;
            out_dst_addr <= '0;
            out_dst_we   <= 1'b0;
            out_is_load  <= 1'b0;
            out_valid    <= 1'b0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            out_dst_we <= 1'b0;
        end else if (!out_stall) begin
            out_valid  <= capture;
            out_dst_we <= capture && dst_we;
            if (capture) begin
                op0          <= sel0;
                op1          <= sel1;
                out_dst_addr <= dst_addr;
                out_is_load  <= is_load;
            end
        end
    end
endmodule

// File: tb/tb_operand_fetch_stage.sv
// tb_operand_fetch_stage: directed and randomized checks of operand_fetch_stage against a cycle-level model.
module tb_operand_fetch_stage;
    logic        clk = 1'b0;
    logic        rst_all = 1'b1;
    logic        in_valid, in_ready;
    logic [4:0]  src0_addr, src1_addr, dst_addr;
    logic        dst_we, is_load;
    logic [4:0]  read0_addr, read1_addr;
    logic [31:0] read0_data, read1_data;
    logic        ex_we, ex_is_load;
    logic [4:0]  ex_addr;
    logic [31:0] ex_data;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        out_stall, flush;
    logic [31:0] op0, op1;
    logic [4:0]  out_dst_addr;
    logic        out_dst_we, out_is_load, out_valid;

    int n_checks = 0;
    int n_fail = 0;

    logic [31:0] regs [32];
    logic [31:0] m_op0, m_op1;
    logic [4:0]  m_dst;
    logic        m_we, m_load, m_valid, m_bub;

    operand_fetch_stage dut (
        .clk(clk), .rst_all(rst_all), .in_valid(in_valid), .in_ready(in_ready),
        .src0_addr(src0_addr), .src1_addr(src1_addr), .dst_addr(dst_addr),
        .dst_we(dst_we), .is_load(is_load), .read0_addr(read0_addr), .read1_addr(read1_addr),
        .read0_data(read0_data), .read1_data(read1_data), .ex_we(ex_we), .ex_is_load(ex_is_load),
        .ex_addr(ex_addr), .ex_data(ex_data), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_stall(out_stall), .flush(flush), .op0(op0), .op1(op1), .out_dst_addr(out_dst_addr),
        .out_dst_we(out_dst_we), .out_is_load(out_is_load), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    // The bench plays the register file: combinational read, write on the clock edge.
    assign read0_data = regs[read0_addr];
    assign read1_data = regs[read1_addr];

    function automatic logic [31:0] fwd(input logic [4:0] a, input logic [31:0] rd);
        if (a == 5'd31) return 32'd0;
        if (ex_we && !ex_is_load && ex_addr == a) return ex_data;
        if (wb_we && wb_addr == a) return wb_data;
        return rd;
    endfunction

    function automatic logic load_use();
        return in_valid && ex_we && ex_is_load && ex_addr != 5'd31 &&
               (ex_addr == src0_addr || ex_addr == src1_addr);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge rst_all) begin
        if (rst_all) begin
            for (int i = 0; i < 32; i++) regs[i] <= 32'hC0DE_0000 | i;
            regs[3] <= 32'h11;
            regs[4] <= 32'hDEAD;
            regs[7] <= 32'h0;
            m_op0 <= 0; m_op1 <= 0; m_dst <= 0;
            m_we <= 0; m_load <= 0; m_valid <= 0; m_bub <= 0;
        end else begin
            if (wb_we) regs[wb_addr] <= wb_data;
            if (flush) begin
                m_valid <= 0; m_we <= 0; m_bub <= 0;
            end else if (!out_stall) begin
                if (m_bub) begin
                    m_bub <= 0; m_valid <= 0; m_we <= 0;
                end else if (load_use()) begin
                    m_bub <= 1; m_valid <= 0; m_we <= 0;
                end else if (in_valid) begin
                    m_valid <= 1; m_we <= dst_we; m_load <= is_load; m_dst <= dst_addr;
                    m_op0 <= fwd(src0_addr, regs[src0_addr]);
                    m_op1 <= fwd(src1_addr, regs[src1_addr]);
                end else begin
                    m_valid <= 0; m_we <= 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_all) begin
            check("out_valid", out_valid, m_valid);
            check("out_dst_we", out_dst_we, m_we);
            check("in_ready", in_ready, !out_stall && !m_bub && !load_use());
            check("read0_addr", read0_addr, src0_addr);
            check("read1_addr", read1_addr, src1_addr);
            if (m_valid) begin
                check("op0", op0, m_op0);
                check("op1", op1, m_op1);
                check("out_dst_addr", out_dst_addr, m_dst);
                check("out_is_load", out_is_load, m_load);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 0; src0_addr = 0; src1_addr = 0; dst_addr = 0; dst_we = 0; is_load = 0;
        ex_we = 0; ex_is_load = 0; ex_addr = 0; ex_data = 0;
        wb_we = 0; wb_addr = 0; wb_data = 0; out_stall = 0; flush = 0;
    endtask

    function automatic logic [4:0] rnd_addr();
        return ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 4));
    endfunction

    initial begin
        idle();
        cyc(); cyc();
        rst_all = 0;
        #1 check("ready_after_reset", in_ready, 1);
        check("valid_after_reset", out_valid, 0);
        cyc();
        // EX forwarding takes priority over WB.
        in_valid = 1; src0_addr = 3; src1_addr = 31; dst_addr = 9; dst_we = 1;
        ex_we = 1; ex_addr = 3; ex_data = 32'hAAAA_0001;
        wb_we = 1; wb_addr = 3; wb_data = 32'h5;
        cyc();
        check("ex_fwd_op0", op0, 32'hAAAA_0001);
        check("ex_fwd_valid", out_valid, 1);
        ex_we = 0; src0_addr = 0; src1_addr = 7; wb_addr = 7; wb_data = 32'h1234;
        cyc();
        check("wb_fwd_op1", op1, 32'h1234);
        wb_we = 0; src0_addr = 31; ex_we = 1; ex_addr = 31; ex_data = 32'hFFFF_FFFF;
        cyc();
        check("zero_reg_op0", op0, 0);
        // Load-use: one bubble, then WB supplies the loaded value.
        src0_addr = 1; src1_addr = 4; dst_addr = 12; ex_we = 1; ex_is_load = 1; ex_addr = 4;
        #1 check("hazard_ready", in_ready, 0);
        cyc();
        check("bubble_valid", out_valid, 0);
        check("bubble_dst_we", out_dst_we, 0);
        ex_we = 0; ex_is_load = 0;
        #1 check("bubble_ready", in_ready, 0);
        cyc();
        wb_we = 1; wb_addr = 4; wb_data = 32'h77;
        #1 check("post_bubble_ready", in_ready, 1);
        cyc();
        check("load_use_op1", op1, 32'h77);
        check("load_use_valid", out_valid, 1);
        // Stall holds outputs; flush wins over stall.
        wb_we = 0; src0_addr = 2; src1_addr = 31; ex_we = 1; ex_addr = 2; ex_data = 32'h5A5A_5A5A;
        cyc();
        check("pre_stall_op0", op0, 32'h5A5A_5A5A);
        out_stall = 1; ex_data = 32'h1;
        for (int i = 0; i < 3; i++) begin
            #1 check("stall_ready", in_ready, 0);
            cyc();
            check("stall_valid", out_valid, 1);
            check("stall_op0", op0, 32'h5A5A_5A5A);
        end
        flush = 1;
        cyc();
        check("flush_valid", out_valid, 0);
        check("flush_dst_we", out_dst_we, 0);
        flush = 0; out_stall = 0; ex_we = 0;
        // Back-to-back issue.
        for (int i = 0; i < 4; i++) begin
            in_valid = 1; src0_addr = 5'(i); src1_addr = 5'(i + 1); dst_addr = 5'(10 + i); dst_we = 1;
            cyc();
            check("b2b_valid", out_valid, 1);
            check("b2b_dst", out_dst_addr, 32'(10 + i));
        end
        // Async reset mid-stream clears outputs without a clock edge.
        rst_all = 1;
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_dst_we", out_dst_we, 0);
        check("rst_op0", op0, 0);
        check("rst_op1", op1, 0);
        check("rst_dst", out_dst_addr, 0);
        check("rst_is_load", out_is_load, 0);
        idle();
        cyc();
        rst_all = 0;
        #1 check("rst_release_ready", in_ready, 1);
        cyc();
        for (int n = 0; n < 3000; n++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            src0_addr = rnd_addr(); src1_addr = rnd_addr(); dst_addr = rnd_addr();
            dst_we = 1'($urandom); is_load = 1'($urandom);
            ex_we = 1'($urandom); ex_is_load = ($urandom_range(0, 2) == 0);
            ex_addr = rnd_addr(); ex_data = $urandom;
            wb_we = 1'($urandom); wb_addr = rnd_addr(); wb_data = $urandom;
            out_stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 15) == 0);
            cyc();
        end
        idle();
        cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
